// File: rtl/mmu_tlb.sv
// Fully associative TLB: combinational lookup with same-cycle write bypass,
// dedup/explicit/round-robin write targeting, flush, and a saturating miss counter.
module mmu_tlb #(
    parameter int unsigned PAGE_NUM_WIDTH = 20,
    parameter int unsigned ENTRIES        = 4,
    localparam int unsigned IDX_W         = $clog2(ENTRIES)
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      stall,
    input  logic                      mmu_en,
    input  logic                      mmu_update,
    input  logic                      tlb_we,
    input  logic                      tlb_idx_valid,
    input  logic [IDX_W-1:0]          tlb_idx,
    input  logic                      tlb_flush,
    input  logic [PAGE_NUM_WIDTH-1:0] vpage_in,
    input  logic [PAGE_NUM_WIDTH-1:0] ppage_in,
    input  logic [31:0]               vaddr_in,
    input  logic                      addr_valid,
    output logic [31:0]               paddr_o,
    output logic                      mmu_error_o,
    output logic [IDX_W-1:0]          hit_idx_o,
    output logic [15:0]               miss_cnt_o
);

    localparam int unsigned OFF_W = 32 - PAGE_NUM_WIDTH;

    typedef struct packed {
        logic [PAGE_NUM_WIDTH-1:0] vpage;
        logic [PAGE_NUM_WIDTH-1:0] ppage;
    } entry_t;

    entry_t                    entry_q [ENTRIES];
    logic [ENTRIES-1:0]        valid_q;
    logic [ENTRIES-1:0]        valid_d;
    logic [IDX_W-1:0]          rr_q;
    logic [IDX_W-1:0]          rr_d;
    logic                      en_q;
    logic [15:0]               miss_q;

    logic [PAGE_NUM_WIDTH-1:0] page_c;
    logic                      en_c;
    logic                      bypass_c;
    logic                      look_hit;
    logic [IDX_W-1:0]          look_idx;
    logic [PAGE_NUM_WIDTH-1:0] look_ppage;
    logic                      wr_match;
    logic [IDX_W-1:0]          wr_match_idx;
    logic [IDX_W-1:0]          wr_idx;
    logic                      count_miss;

    // Associative search: one port for the lookup page, one for the write page.
    always_comb begin
        page_c       = vaddr_in[31:OFF_W];
        look_hit     = 1'b0;
        look_idx     = '0;
        look_ppage   = '0;
        wr_match     = 1'b0;
        wr_match_idx = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (valid_q[i] && (entry_q[i].vpage == page_c)) begin
                look_hit   = 1'b1;
                look_idx   = IDX_W'(i);
                look_ppage = entry_q[i].ppage;
            end
            if (valid_q[i] && (entry_q[i].vpage == vpage_in)) begin
                wr_match     = 1'b1;
                wr_match_idx = IDX_W'(i);
            end
        end
    end

    // Write target and replacement pointer; a flush empties the table first,
    // so an existing match is meaningless in that cycle.
    always_comb begin
        wr_idx = rr_q;
        rr_d   = rr_q;
        if (tlb_flush) begin
            wr_idx = tlb_idx_valid ? tlb_idx : '0;
            rr_d   = (tlb_we && !tlb_idx_valid) ? IDX_W'(1) : '0;
        end else if (wr_match) begin
            wr_idx = wr_match_idx;
        end else if (tlb_idx_valid) begin
            wr_idx = tlb_idx;
        end else if (tlb_we) begin
            rr_d = rr_q + IDX_W'(1);
        end
        valid_d = tlb_flush ? '0 : valid_q;
        if (tlb_we) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Translation outputs; the in-flight write takes precedence over stored entries.
    always_comb begin
        en_c        = mmu_update ? mmu_en : en_q;
        bypass_c    = tlb_we && (vpage_in == page_c);
        paddr_o     = vaddr_in;
        mmu_error_o = 1'b0;
        hit_idx_o   = '0;
        if (en_c) begin
            if (bypass_c) begin
                paddr_o   = {ppage_in, vaddr_in[OFF_W-1:0]};
                hit_idx_o = wr_idx;
            end else if (look_hit) begin
                paddr_o   = {look_ppage, vaddr_in[OFF_W-1:0]};
                hit_idx_o = look_idx;
            end else begin
                mmu_error_o = 1'b1;
            end
        end
        count_miss = addr_valid && mmu_error_o;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            en_q    <= 1'b0;
            valid_q <= '0;
            rr_q    <= '0;
            miss_q  <= '0;
        end else if (!stall) begin
            if (mmu_update) begin
                en_q <= mmu_en;
            end
            valid_q <= valid_d;
            rr_q    <= rr_d;
            miss_q  <= (count_miss && (miss_q != 16'hFFFF)) ? miss_q + 16'd1 : miss_q;
        end
    end

    // Page fields carry no reset; validity alone gates their use.
    always_ff @(posedge clk) begin
        if (tlb_we && !stall) begin
            entry_q[wr_idx] <= '{vpage: vpage_in, ppage: ppage_in};
        end
    end

    assign miss_cnt_o = miss_q;

endmodule

// File: tb/tb_mmu_tlb.sv
// Directed bench for mmu_tlb (PAGE_NUM_WIDTH=20, ENTRIES=4) with hand-computed
// expectations for translation, replacement, flush, miss counting and reset.
module tb_mmu_tlb;

    logic        clk;
    logic        clr;
    logic        stall;
    logic        mmu_en;
    logic        mmu_update;
    logic        tlb_we;
    logic        tlb_idx_valid;
    logic [1:0]  tlb_idx;
    logic        tlb_flush;
    logic [19:0] vpage_in;
    logic [19:0] ppage_in;
    logic [31:0] vaddr_in;
    logic        addr_valid;
    logic [31:0] paddr_o;
    logic        mmu_error_o;
    logic [1:0]  hit_idx_o;
    logic [15:0] miss_cnt_o;

    int n_cmp;
    int n_bad;

    mmu_tlb #(.PAGE_NUM_WIDTH(20), .ENTRIES(4)) dut (
        .clk           (clk),
        .clr           (clr),
        .stall         (stall),
        .mmu_en        (mmu_en),
        .mmu_update    (mmu_update),
        .tlb_we        (tlb_we),
        .tlb_idx_valid (tlb_idx_valid),
        .tlb_idx       (tlb_idx),
        .tlb_flush     (tlb_flush),
        .vpage_in      (vpage_in),
        .ppage_in      (ppage_in),
        .vaddr_in      (vaddr_in),
        .addr_valid    (addr_valid),
        .paddr_o       (paddr_o),
        .mmu_error_o   (mmu_error_o),
        .hit_idx_o     (hit_idx_o),
        .miss_cnt_o    (miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One write cycle; the lookup page is parked on a page never stored.
    task automatic wr(input logic [19:0] vp, input logic [19:0] pp,
                      input logic iv, input logic [1:0] idx);
        vaddr_in      = 32'hFFFF_F000;
        tlb_we        = 1'b1;
        vpage_in      = vp;
        ppage_in      = pp;
        tlb_idx_valid = iv;
        tlb_idx       = idx;
        step();
        tlb_we        = 1'b0;
        tlb_idx_valid = 1'b0;
    endtask

    task automatic look(input string tag, input logic [19:0] pg, input logic exp_hit,
                        input logic [1:0] exp_idx, input logic [19:0] exp_pp);
        vaddr_in = {pg, 12'h678};
        #1;
        if (exp_hit) begin
            check({tag, "/err"},   32'(mmu_error_o), 32'd0);
            check({tag, "/paddr"}, paddr_o, {exp_pp, 12'h678});
            check({tag, "/idx"},   32'(hit_idx_o), 32'(exp_idx));
        end else begin
            check({tag, "/err"},   32'(mmu_error_o), 32'd1);
            check({tag, "/paddr"}, paddr_o, {pg, 12'h678});
            check({tag, "/idx"},   32'(hit_idx_o), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clr = 1'b0; stall = 1'b0; mmu_en = 1'b0; mmu_update = 1'b0;
        tlb_we = 1'b0; tlb_idx_valid = 1'b0; tlb_idx = 2'd0; tlb_flush = 1'b0;
        vpage_in = '0; ppage_in = '0; vaddr_in = 32'h1234_5678; addr_valid = 1'b0;

        step();
        step();
        clr = 1'b1;
        #1;
        check("rst/paddr", paddr_o, 32'h1234_5678);
        check("rst/err",   32'(mmu_error_o), 32'd0);
        check("rst/idx",   32'(hit_idx_o), 32'd0);
        check("rst/miss",  32'(miss_cnt_o), 32'd0);

        mmu_update = 1'b1; mmu_en = 1'b1;
        step();
        mmu_update = 1'b0;
        wr(20'h12345, 20'h00ABC, 1'b0, 2'd0);
        look("first_hit", 20'h12345, 1'b1, 2'd0, 20'h00ABC);
        look("first_miss", 20'h00001, 1'b0, 2'd0, 20'h0);

        // mmu_update with mmu_en=0 overrides en_reg combinationally
        mmu_update = 1'b1; mmu_en = 1'b0; vaddr_in = 32'h1234_5678;
        #1;
        check("ovr/paddr", paddr_o, 32'h1234_5678);
        check("ovr/err",   32'(mmu_error_o), 32'd0);
        mmu_update = 1'b0; mmu_en = 1'b1;

        tlb_flush = 1'b1;
        step();
        tlb_flush = 1'b0;
        look("flushed", 20'h12345, 1'b0, 2'd0, 20'h0);

        // Round-robin fill and wrap
        for (int i = 0; i < 5; i++) begin
            wr(20'h00010 + 20'(i), 20'h00110 + 20'(i), 1'b0, 2'd0);
        end
        look("rr_evicted", 20'h00010, 1'b0, 2'd0, 20'h0);
        look("rr_wrap",    20'h00014, 1'b1, 2'd0, 20'h00114);
        look("rr_e1",      20'h00011, 1'b1, 2'd1, 20'h00111);
        wr(20'h00012, 20'h00777, 1'b0, 2'd0);
        look("rewrite",    20'h00012, 1'b1, 2'd2, 20'h00777);
        wr(20'h00020, 20'h00120, 1'b0, 2'd0);
        look("rr_held",    20'h00020, 1'b1, 2'd1, 20'h00120);
        look("rr_held_ev", 20'h00011, 1'b0, 2'd0, 20'h0);
        wr(20'h00030, 20'h00130, 1'b1, 2'd3);
        look("explicit",   20'h00030, 1'b1, 2'd3, 20'h00130);
        look("explicit_ev", 20'h00013, 1'b0, 2'd0, 20'h0);
        wr(20'h00030, 20'h00333, 1'b1, 2'd0);
        look("dedup",      20'h00030, 1'b1, 2'd3, 20'h00333);
        look("dedup_keep", 20'h00014, 1'b1, 2'd0, 20'h00114);
        wr(20'h00040, 20'h00140, 1'b0, 2'd0);
        look("rr_after",   20'h00040, 1'b1, 2'd2, 20'h00140);

        stall = 1'b1;
        wr(20'h00050, 20'h00150, 1'b0, 2'd0);
        stall = 1'b0;
        look("stall_wr",   20'h00050, 1'b0, 2'd0, 20'h0);

        // Miss counting over three cycles, the middle one stalled
        vaddr_in = 32'h0009_9678; addr_valid = 1'b1;
        #1;
        check("cnt/err", 32'(mmu_error_o), 32'd1);
        step();
        check("cnt/1", 32'(miss_cnt_o), 32'd1);
        stall = 1'b1;
        #1;
        check("cnt/stall_err", 32'(mmu_error_o), 32'd1);
        step();
        stall = 1'b0;
        check("cnt/stalled", 32'(miss_cnt_o), 32'd1);
        step();
        check("cnt/2", 32'(miss_cnt_o), 32'd2);
        tlb_we = 1'b1; vpage_in = 20'h00099; ppage_in = 20'h00055;
        #1;
        check("bypass/err",   32'(mmu_error_o), 32'd0);
        check("bypass/paddr", paddr_o, 32'h0005_5678);
        step();
        tlb_we = 1'b0; addr_valid = 1'b0;
        check("bypass/cnt", 32'(miss_cnt_o), 32'd2);
        look("bypass_stored", 20'h00099, 1'b1, 2'd3, 20'h00055);

        // Flush + write at explicit index 2
        tlb_flush = 1'b1;
        wr(20'h00077, 20'h00066, 1'b1, 2'd2);
        tlb_flush = 1'b0;
        look("fw_hit",   20'h00077, 1'b1, 2'd2, 20'h00066);
        look("fw_old0",  20'h00014, 1'b0, 2'd0, 20'h0);
        look("fw_old3",  20'h00099, 1'b0, 2'd0, 20'h0);
        wr(20'h00088, 20'h00188, 1'b0, 2'd0);
        look("fw_rr0",   20'h00088, 1'b1, 2'd0, 20'h00188);

        // Flush + write via pointer lands at 0 and advances pointer to 1
        tlb_flush = 1'b1;
        wr(20'h000A1, 20'h001A1, 1'b0, 2'd0);
        tlb_flush = 1'b0;
        wr(20'h000A2, 20'h001A2, 1'b0, 2'd0);
        look("fr_e0",   20'h000A1, 1'b1, 2'd0, 20'h001A1);
        look("fr_e1",   20'h000A2, 1'b1, 2'd1, 20'h001A2);
        look("fr_old",  20'h00077, 1'b0, 2'd0, 20'h0);
        tlb_flush = 1'b1;
        wr(20'h000A2, 20'h002A2, 1'b1, 2'd3);
        tlb_flush = 1'b0;
        look("fr_nodedup", 20'h000A2, 1'b1, 2'd3, 20'h002A2);
        wr(20'h000B1, 20'h001B1, 1'b0, 2'd0);
        look("fr_rr0",  20'h000B1, 1'b1, 2'd0, 20'h001B1);

        // Reset beats a stalled write
        clr = 1'b0; stall = 1'b1;
        wr(20'h000C0, 20'h001C0, 1'b0, 2'd0);
        clr = 1'b1; stall = 1'b0;
        vaddr_in = 32'h000C_0678;
        #1;
        check("rst2/paddr", paddr_o, 32'h000C_0678);
        check("rst2/err",   32'(mmu_error_o), 32'd0);
        check("rst2/miss",  32'(miss_cnt_o), 32'd0);
        mmu_update = 1'b1;
        step();
        mmu_update = 1'b0;
        look("rst2_wr", 20'h000C0, 1'b0, 2'd0, 20'h0);
        look("rst2_old", 20'h000B1, 1'b0, 2'd0, 20'h0);

        // Saturation
        vaddr_in = 32'h0009_9678; addr_valid = 1'b1;
        force dut.miss_q = 16'hFFFF;
        step();
        release dut.miss_q;
        #1;
        check("sat/0", 32'(miss_cnt_o), 32'h0000_FFFF);
        step();
        check("sat/1", 32'(miss_cnt_o), 32'h0000_FFFF);
        step();
        check("sat/2", 32'(miss_cnt_o), 32'h0000_FFFF);
        addr_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmu_tlb.md
MMU_TLB -- requirements
Module: mmu_tlb

Interface
REQ-001 Parameter PAGE_NUM_WIDTH, default 20, SHALL set virtual/physical page-number width; offset width = 32-PAGE_NUM_WIDTH.
REQ-002 Parameter ENTRIES, default 4, SHALL set the TLB entry count; power of 2, range 2..16; IDX_W = log2(ENTRIES).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 clr  in  1  SHALL be the reset, synchronous and active-low.
REQ-005 stall  in  1  SHALL freeze all state updates while HIGH.
REQ-006 mmu_en  in  1  SHALL be HIGH for user mode (translate) and LOW for kernel mode (bypass).
REQ-007 mmu_update  in  1  SHALL load mmu_en into the mode register.
REQ-008 tlb_we  in  1  SHALL request one entry write.
REQ-009 tlb_idx_valid  in  1  SHALL select an explicit write index when HIGH.
REQ-010 tlb_idx  in  IDX_W  SHALL be the explicit write index.
REQ-011 tlb_flush  in  1  SHALL invalidate all entries.
REQ-012 vpage_in, ppage_in  in  PAGE_NUM_WIDTH each  SHALL be the write data.
REQ-013 vaddr_in  in  32  SHALL be the virtual address to translate.
REQ-014 addr_valid  in  1  SHALL qualify vaddr_in for miss counting.
REQ-015 paddr_o  out  32  SHALL be the translated address.
REQ-016 mmu_error_o  out  1  SHALL flag a translation miss.
REQ-017 hit_idx_o  out  IDX_W  SHALL give the matching entry index; 0 when there is no hit.
REQ-018 miss_cnt_o  out  16  SHALL count qualified misses.

Function
REQ-019 Each entry SHALL hold valid, vpage and ppage; lookup SHALL be fully associative and combinational on vaddr_in[31:32-PAGE_NUM_WIDTH].
REQ-020 Effective mode SHALL be en = mmu_update ? mmu_en : en_reg.
REQ-021 en_reg SHALL load mmu_en on a clock with mmu_update & ~stall.
REQ-022 en=0: paddr_o = vaddr_in, mmu_error_o = 0, hit_idx_o = 0.
REQ-023 en=1 with hit: paddr_o = {ppage, vaddr_in offset}, mmu_error_o = 0.
REQ-024 en=1 with miss: paddr_o = vaddr_in, mmu_error_o = 1.
REQ-025 Write bypass: when tlb_we=1 and the vaddr page equals vpage_in, the lookup SHALL hit with ppage_in in the same cycle, ahead of stored entries.
REQ-026 Write target, on tlb_we & ~stall, SHALL be chosen in this priority:
  - (a) the valid entry whose vpage equals vpage_in (no duplicates);
  - (b) tlb_idx, if tlb_idx_valid;
  - (c) round-robin pointer rr_ptr.
REQ-027 The written entry SHALL be set valid with vpage_in and ppage_in.
REQ-028 rr_ptr SHALL increment modulo ENTRIES only when case (c) is used; it wraps from ENTRIES-1 to 0.
REQ-029 tlb_flush & ~stall SHALL clear all valid bits and set rr_ptr = 0.
REQ-030 Flush and write in the same cycle: the flush SHALL apply first, then the write lands at tlb_idx (if tlb_idx_valid) or index 0.
  - Case (a) SHALL be ignored in this cycle.
  - rr_ptr SHALL become 1 if index 0 came from rr_ptr, else stay 0.
REQ-031 Stored entry contents SHALL be unique by construction; multiple hits SHALL not occur.
REQ-032 miss_cnt_o SHALL increment on addr_valid & mmu_error_o & ~stall, and saturate at 16'hFFFF.
REQ-033 While stall=1, the combinational outputs SHALL still track their inputs and registered state.
REQ-034 mmu_update and tlb_we SHALL be independent; both may apply in one cycle.

Reset
REQ-035 clr=0 at a clock edge SHALL clear en_reg, all valid bits, rr_ptr and miss_cnt_o, regardless of stall or any other input.
REQ-036 Reset SHALL override a write or flush in the same cycle.
REQ-037 After reset, all outputs SHALL follow REQ-022 (bypass) until mmu_update sets en_reg.
REQ-038 Entry vpage/ppage fields SHALL need no reset.

Verification
REQ-039 Reset, then vaddr_in=32'h1234_5678 with en_reg=0 -> paddr_o=32'h1234_5678, mmu_error_o=0, miss_cnt_o=0.
REQ-040 Set en_reg=1, write vpage 20'h12345 -> ppage 20'h00ABC, then lookup 32'h1234_5678 -> paddr_o=32'h00AB_C678, hit_idx_o=0.
REQ-041 ENTRIES=4, five round-robin writes of distinct vpages -> fifth write lands in entry 0 and the first vpage misses; a rewrite of an existing vpage reuses its entry and rr_ptr does not move.
REQ-042 Miss with addr_valid=1 for 3 cycles, one of them with stall=1 -> miss_cnt_o=2; same-cycle tlb_we with a matching vpage -> hit via bypass, no count.
REQ-043 Same-cycle flush + write at tlb_idx=2 -> only entry 2 valid; prior entries miss.
REQ-044 clr=0 asserted during tlb_we -> no entry valid after reset; miss_cnt_o preset to FFFF by force -> stays FFFF on further misses.
